// File: rtl/alu_pkg.sv
// Shared ALU definitions: alu_control codes, execute-unit state encoding, default width.
// Imported by the ALU decoder and alu_exec_unit so the op codes live in one place.
package alu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } alu_state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle of alu_exec_unit: operand valid/ready in, result valid/ready out.
// ALU_EXEC_SRA_EN adds sra_sel (arithmetic right shift select) to the request side.
interface alu_exec_unit_if #(
    parameter int unsigned XLEN = alu_pkg::XLEN_DEFAULT
);

    logic            in_valid;
    logic            in_ready;
    logic [2:0]      alu_control;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
`ifdef ALU_EXEC_SRA_EN
    logic            sra_sel;

    modport master (
        output in_valid, alu_control, src_a, src_b, sra_sel, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, alu_control, src_a, src_b, sra_sel, out_ready,
        output in_ready, out_valid, result, zero
    );
`else
    modport master (
        output in_valid, alu_control, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, alu_control, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero
    );
`endif

endinterface

// File: rtl/alu_shift_step.sv
// Combinational shifter moving data by 0..SHIFT_STEP bits per call, left or right,
// with a selectable fill bit for right shifts (zero for SRL, sign for SRA).
module alu_shift_step #(
    parameter  int unsigned XLEN       = 32,
    parameter  int unsigned SHIFT_STEP = 1,
    localparam int unsigned AMT_W      = $clog2(SHIFT_STEP) + 1
) (
    input  logic [XLEN-1:0]  data_i,
    input  logic [AMT_W-1:0] amt_i,
    input  logic             right_i,
    input  logic             fill_i,
    output logic [XLEN-1:0]  data_o
);

    always_comb begin
        data_o = data_i << amt_i;
        if (right_i) begin
            // Vacated high bits are the complement of an all-ones mask shifted right.
            data_o = (data_i >> amt_i) | ({XLEN{fill_i}} & ~({XLEN{1'b1}} >> amt_i));
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute unit: single-cycle logic/add/sub, iterative shifts of
// SHIFT_STEP bits per cycle. Optional macro ALU_EXEC_SRA_EN enables arithmetic SRL via sra_sel.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEFAULT,
    parameter int unsigned SHIFT_STEP = 1
) (
    input logic               clk,
    input logic               rst_n,
    alu_exec_unit_if.slave    bus
);

    localparam int unsigned SH_W  = $clog2(XLEN);
    localparam int unsigned AMT_W = $clog2(SHIFT_STEP) + 1;

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [SH_W-1:0] rem_q, rem_d;
    logic            right_q, right_d;
    logic            fill_q, fill_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;

    logic [SH_W-1:0]  amt_in;
    logic             is_shift;
    logic             fill_in;
    logic [XLEN-1:0]  calc;
    logic [31:0]      rem32;
    logic [SH_W-1:0]  step;
    logic [SH_W-1:0]  rem_next;
    logic [AMT_W-1:0] step_amt;
    logic [XLEN-1:0]  shift_out;

    alu_shift_step #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shift_step (
        .data_i  (work_q),
        .amt_i   (step_amt),
        .right_i (right_q),
        .fill_i  (fill_q),
        .data_o  (shift_out)
    );

    // Request-side decode: shift amount, fill bit and the single-cycle result.
    always_comb begin
        amt_in   = bus.src_b[SH_W-1:0];
        is_shift = (bus.alu_control == ALU_SLL) || (bus.alu_control == ALU_SRL);
        fill_in  = 1'b0;
`ifdef ALU_EXEC_SRA_EN
        if ((bus.alu_control == ALU_SRL) && bus.sra_sel) begin
            fill_in = bus.src_a[XLEN-1];
        end
`endif
        case (bus.alu_control)
            ALU_ADD: calc = bus.src_a + bus.src_b;
            ALU_SUB: calc = bus.src_a - bus.src_b;
            ALU_XOR: calc = bus.src_a ^ bus.src_b;
            ALU_OR:  calc = bus.src_a | bus.src_b;
            ALU_AND: calc = bus.src_a & bus.src_b;
            ALU_SLL: calc = bus.src_a;
            ALU_SRL: calc = bus.src_a;
            default: calc = '0;
        endcase
    end

    // Iteration step: min(SHIFT_STEP, remaining); a step of SHIFT_STEP==XLEN never
    // fits in SH_W bits, but then remaining is always below it.
    always_comb begin
        rem32    = 32'(rem_q);
        step     = (rem32 < SHIFT_STEP) ? rem_q : SH_W'(SHIFT_STEP);
        rem_next = rem_q - step;
        step_amt = AMT_W'(step);
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        rem_d    = rem_q;
        right_d  = right_q;
        fill_d   = fill_q;
        result_d = result_q;
        zero_d   = zero_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (is_shift && (amt_in != '0)) begin
                        work_d  = bus.src_a;
                        rem_d   = amt_in;
                        right_d = (bus.alu_control == ALU_SRL);
                        fill_d  = fill_in;
                        state_d = SHIFT;
                    end else begin
                        result_d = calc;
                        zero_d   = (calc == '0);
                        state_d  = DONE;
                    end
                end
            end
            SHIFT: begin
                work_d = shift_out;
                rem_d  = rem_next;
                if (rem_next == '0) begin
                    result_d = shift_out;
                    zero_d   = (shift_out == '0);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            work_q   <= '0;
            rem_q    <= '0;
            right_q  <= 1'b0;
            fill_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            rem_q    <= rem_d;
            right_q  <= right_d;
            fill_q   <= fill_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.result    = result_q;
        bus.zero      = zero_q;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Multi-cycle execute unit that consumes the 3-bit alu_control code produced by the ALU decoder.
- Takes operands in through a valid/ready handshake and returns the result plus a zero flag through a second valid/ready handshake.
- Logic ops, add and sub complete in one cycle. Shifts run iteratively, SHIFT_STEP bits per cycle, to keep the datapath small.
- Sits between the register-read stage and writeback/branch-compare in the multi-cycle core variant.

Parameters:
- XLEN, 32, operand/result width (power of 2, ≥8).
- SHIFT_STEP, 1, bits shifted per iteration cycle (power of 2, 1..XLEN).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept a request.
- alu_control  input  3  op code: 000 ADD, 010 SUB, 001 SLL, 101 SRL, 100 XOR, 110 OR, 111 AND, 011 reserved.
- src_a  input  XLEN  operand A.
- src_b  input  XLEN  operand B; shift amount is src_b[log2(XLEN)-1:0].
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  XLEN  operation result.
- zero  output  1  result == 0.

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; result=0; zero=1; shift counter=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1. Accept when in_valid&&in_ready; latch operands and opcode.
  - Non-shift op, or shift with amount 0: compute in the accept cycle, register result, go to DONE. out_valid rises the cycle after accept (latency 1).
  - Shift with amount k>0: load src_a into the working register, remaining=k, go to SHIFT.
- SHIFT:
  - in_ready=0. Each cycle shift the working register by s=min(SHIFT_STEP, remaining) and set remaining-=s.
  - When remaining reaches 0 after the update, go to DONE.
  - Latency: 1+ceil(k/SHIFT_STEP) cycles from accept to out_valid.
- DONE:
  - out_valid=1, in_ready=0. result and zero stay stable until out_valid&&out_ready.
  - On handshake, go to IDLE; out_valid drops next cycle.
  - No same-cycle accept of a new request; throughput is at most 1 op per 2 cycles.
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN; carry/overflow are discarded.
  - SUB is src_a - src_b (used for beq/bne compare via zero).
  - Only the low log2(XLEN) bits of src_b count as the shift amount; upper bits are ignored (e.g. src_b=33 → shift 1 for XLEN=32).
  - SRL fills with zeros unless the optional feature below applies.
- Reserved code 011: treated as non-shift with result=0, zero=1, latency 1.
- Inputs are ignored while in_ready=0. The producer must hold in_valid and its data stable until accepted.
- out_valid never drops without out_ready.
- Reset mid-operation aborts the operation; no partial result is ever presented.

Optional Feature:
- Macro: ALU_EXEC_SRA_EN.
- Defined:
  - Adds input port sra_sel (1 bit), sampled with the request.
  - When alu_control=101 and sra_sel=1, right shifts fill with src_a[XLEN-1] (arithmetic shift).
- Undefined: port absent; 101 is always a logical shift right.

Decomposition:
- Shared package alu_pkg holds:
  - the ALU_ADD/SUB/SLL/SRL/XOR/OR/AND localparams (3-bit codes above);
  - a state enum IDLE/SHIFT/DONE;
  - the XLEN default.
- The ALU decoder and this unit both import alu_pkg so the codes stay in one place.
- One natural sub-module: alu_shift_step, a combinational shifter that shifts by 0..SHIFT_STEP in the selected direction/fill. It is instantiated once inside the SHIFT datapath.

Test Plan (XLEN=32, SHIFT_STEP=1 unless stated):
1. Reset asserted mid-SHIFT (SLL by 20, after 5 cycles) → out_valid=0, in_ready=1, result=0, zero=1 immediately. No result ever appears for that op.
2. ADD 0xFFFFFFFF+1 → result=0, zero=1, out_valid 1 cycle after accept. SUB 5-7 → 0xFFFFFFFE, zero=0.
3. SLL 0x1 by src_b=0x25 (amount 5) → result=0x20, out_valid 6 cycles after accept. Repeat with SHIFT_STEP=4 → 3 cycles.
4. SRL 0x80000000 by 31 → 0x1. With ALU_EXEC_SRA_EN and sra_sel=1 → 0xFFFFFFFF. Shift by 0 → result=src_a, latency 1.
5. Backpressure: hold out_ready=0 for 10 cycles after AND 0xF0F0 & 0xFF00 → result=0xF000 stable, out_valid high, in_ready low, and a new in_valid is not accepted.
6. Back-to-back requests with out_ready=1 (XOR, OR, reserved 011) → results 1 per 2 cycles, in order. The 011 op yields result=0, zero=1.
